bus_burst_responder: RTL

- Memory-mapped bus target (responder) for the virtual-prototype bus; the other end of the burst initiator inside the DMA of the custom-instruction RAM block.
- Holds a 512 x 32-bit single-port word RAM and answers single and burst read/write transactions addressed to its window.
- Used as the DMA test target and as scratch memory on the shared bus.
- All outputs are driven 0 when the block is not the active target, so they can be OR-combined onto the bus.

---
 rtl/bus_burst_responder.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/bus_burst_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_burst_responder
// Description : Memory-mapped bus responder holding a (1 << WORD_ADDR_BITS)
//               x 32-bit word RAM. Answers single and burst read/write
//               transactions that fall inside its address window.
//               Outputs are 0 whenever the block is not the active target,
//               so they can be OR-combined onto the shared bus.
// Ports       :
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   beginTransactionIn      - start strobe; address/command/burst valid
//   endTransactionIn        - initiator ends a write burst
//   readNotWriteIn          - 1 = read, 0 = write (sampled with begin)
//   addressDataIn[31:0]     - byte address at begin, write data otherwise
//   byteEnablesIn[3:0]      - write byte lanes, per data word
//   burstSizeIn[7:0]        - burst length in words minus 1
//   dataValidIn             - write data word valid
//   busyIn                  - initiator stalls read data
//   addressDataOut[31:0]    - read data (0 when dataValidOut is 0)
//   dataValidOut            - read data valid
//   endTransactionOut       - one-cycle end of read burst
//   busyOut                 - tied 0, one word per cycle is always accepted
//   errorOut                - one-cycle error pulse
// Revision    : 1.0 - initial release
// ============================================================================
module bus_burst_responder #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h50000000,
  parameter int          WORD_ADDR_BITS = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic        endTransactionIn,
  input  logic        readNotWriteIn,
  input  logic [31:0] addressDataIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        dataValidIn,
  input  logic        busyIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busyOut,
  output logic        errorOut
);

  localparam int c_DEPTH = 1 << WORD_ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_ERR   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                    r_state;
  logic [WORD_ADDR_BITS-1:0] r_ptr;     // next RAM word to fetch / write
  logic [8:0]                r_count;   // words still to fetch / accept
  logic                      r_rnw;
  logic [31:0]               r_dout;
  logic                      r_dv;
  logic                      r_end;
  logic                      r_err;

  logic [31:0]               mem [c_DEPTH];
  logic [31:0]               r_ram_q;   // prefetched next read word

  logic                      w_sel;
  logic                      w_misaligned;
  logic [WORD_ADDR_BITS-1:0] w_begin_word;
  logic                      w_load;
  logic                      w_last;
  logic                      w_wr_accept;
  logic                      w_re;
  logic [WORD_ADDR_BITS-1:0] w_rd_addr;

  assign w_sel        = beginTransactionIn &&
                        (addressDataIn[31:WORD_ADDR_BITS+2] == BASE_ADDRESS[31:WORD_ADDR_BITS+2]);
  assign w_misaligned = (addressDataIn[1:0] != 2'b00);
  assign w_begin_word = addressDataIn[WORD_ADDR_BITS+1:2];

  // Present a new word when the output register is empty or its word has
  // just been accepted, and words remain.
  assign w_load = (r_state == S_READ) && (!r_dv || !busyIn) && (r_count != 9'd0);
  // Final word accepted: close the burst.
  assign w_last = (r_state == S_READ) && r_dv && !busyIn && (r_count == 9'd0);

  assign w_wr_accept = (r_state == S_WRITE) && dataValidIn && (r_count != 9'd0) && !reset;

  // In IDLE the RAM is read at the bus address so the first word is ready
  // one edge after begin. During a read the RAM only advances when a word
  // is consumed, so r_ram_q always holds the word following the output.
  assign w_rd_addr = (r_state == S_IDLE) ? w_begin_word : r_ptr;
  assign w_re      = (r_state == S_IDLE) || w_load;

  always_ff @(posedge clock) begin
    if (w_wr_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEnablesIn[i]) begin
          mem[r_ptr][8*i +: 8] <= addressDataIn[8*i +: 8];
        end
      end
    end
    if (w_re) begin
      r_ram_q <= mem[w_rd_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_count <= 9'd0;
      r_rnw   <= 1'b0;
      r_dout  <= 32'd0;
      r_dv    <= 1'b0;
      r_end   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_end <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dv   <= 1'b0;
          r_dout <= 32'd0;
          if (w_sel) begin
            r_rnw   <= readNotWriteIn;
            r_count <= {1'b0, burstSizeIn} + 9'd1;
            if (w_misaligned) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else if (readNotWriteIn) begin
              // First word is already being fetched this edge.
              r_ptr   <= w_begin_word + WORD_ADDR_BITS'(1);
              r_state <= S_READ;
            end else begin
              r_ptr   <= w_begin_word;
              r_state <= S_WRITE;
            end
          end
        end

        S_READ: begin
          if (w_load) begin
            r_dout  <= r_ram_q;
            r_dv    <= 1'b1;
            r_ptr   <= r_ptr + WORD_ADDR_BITS'(1);
            r_count <= r_count - 9'd1;
          end else if (w_last) begin
            r_dout  <= 32'd0;
            r_dv    <= 1'b0;
            r_end   <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        S_WRITE: begin
          if (dataValidIn) begin
            if (r_count != 9'd0) begin
              r_ptr   <= r_ptr + WORD_ADDR_BITS'(1);
              r_count <= r_count - 9'd1;
            end else begin
              r_err <= 1'b1;
            end
          end
          if (endTransactionIn) begin
            r_state <= S_IDLE;
          end
        end

        S_ERR: begin
          // A misaligned write must still see its end strobe before the bus
          // is released; an end arriving right now already satisfies that.
          if (!r_rnw && !endTransactionIn) begin
            r_state <= S_DRAIN;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_DRAIN: begin
          if (endTransactionIn) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addressDataOut    = r_dout;
  assign dataValidOut      = r_dv;
  assign endTransactionOut = r_end;
  assign errorOut          = r_err;
  assign busyOut           = 1'b0;

endmodule
`default_nettype wire
